mem_access_stage: RTL
=====================

MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 SHALL have parameter MAX_WAIT, default 15: max WAIT-state cycles before a memory access is aborted (legal 1..255).
REQ-002 SHALL use one clock; reset is synchronous and active-high.
REQ-003 SHALL have these ports (clock and reset first):
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- RegWrite_in, MemtoReg_in, MemRead_in, MemWrite_in  in  1 each  control from EX/MEM register
- ALU_result_in  in  32  address / ALU value
- reg_read_data_2_in  in  32  store data
- EX_MEM_RegisterRd_in  in  5  destination register
- mem_req  out  1  data-memory request
- mem_we  out  1  1 = write, 0 = read
- mem_addr  out  32  memory address
- mem_wdata  out  32  memory write data
- mem_ready  in  1  memory completion strobe
- mem_rdata  in  32  read data, valid when mem_ready=1
- mem_stall  out  1  freeze PC, IF/ID, ID/EX and EX/MEM
- RegWrite_out, MemtoReg_out  out  1 each  MEM/WB control
- mem_read_data_out  out  32  MEM/WB load data
- ALU_result_out  out  32  MEM/WB ALU value
- MEM_WB_RegisterRd_out  out  5  MEM/WB destination
- mem_timeout  out  1  sticky abort flag
- mem_misalign  out  1  sticky misaligned-access flag

Function
REQ-004 SHALL implement FSM states IDLE and WAIT, plus a wait counter of 8 bits.
REQ-005 Memory op present = MemRead_in | MemWrite_in; aligned = ALU_result_in[1:0] == 0.
REQ-006 IDLE with no op: mem_req=0, mem_stall=0; the next edge loads MEM/WB from inputs and sets mem_read_data_out=0.
REQ-007 IDLE with an aligned op: mem_req=1 combinationally, with mem_addr=ALU_result_in, mem_wdata=reg_read_data_2_in, and mem_we=MemWrite_in.
REQ-008 If both MemRead_in and MemWrite_in are 1, the access SHALL be a write (mem_we=1), and mem_read_data_out SHALL load 0.
REQ-009 Zero-wait completion: in IDLE with mem_ready=1 in the same cycle, mem_stall=0; the edge loads MEM/WB with mem_read_data_out = read ? mem_rdata : 0; state stays IDLE.
REQ-010 In IDLE with mem_ready=0: mem_stall=1; the edge moves to WAIT, clears the counter and loads a MEM/WB bubble.
REQ-011 Bubble SHALL mean RegWrite_out=0, MemtoReg_out=0, MEM_WB_RegisterRd_out=0; the data outputs SHALL hold their previous value.
REQ-012 In WAIT: mem_req=1 and mem_addr/mem_we/mem_wdata are driven from the inputs, which upstream holds stable because of the stall.
REQ-013 In WAIT with mem_ready=1: mem_stall=0 that cycle; the edge completes as in REQ-009 and returns to IDLE.
REQ-014 In WAIT with mem_ready=0 and counter < MAX_WAIT-1: mem_stall=1; the counter increments; a bubble is loaded.
REQ-015 In WAIT with mem_ready=0 and counter == MAX_WAIT-1: mem_req=0 and mem_stall=0 that cycle; the edge sets mem_timeout=1, loads a bubble and returns to IDLE.
REQ-016 Maximum stall per access SHALL be MAX_WAIT cycles.
REQ-017 An op with misaligned address in IDLE: mem_req=0, mem_stall=0; the edge sets mem_misalign=1 and loads a bubble.
REQ-018 mem_timeout and mem_misalign SHALL be sticky until reset.
REQ-019 mem_ready SHALL be ignored whenever mem_req=0.

Reset
REQ-020 A reset sampled high at a clock edge SHALL, regardless of state (including mid-WAIT), set state=IDLE, counter=0, all MEM/WB outputs=0, and mem_timeout=mem_misalign=0.
REQ-021 While reset is high, mem_req and mem_stall SHALL be forced to 0.

Verification
REQ-022 Load, zero-wait: MemRead_in=1, MemtoReg_in=1, RegWrite_in=1, addr 0x100, Rd=5, mem_ready=1, mem_rdata=0xDEADBEEF -> no stall; next cycle RegWrite_out=1, MemtoReg_out=1, mem_read_data_out=0xDEADBEEF, Rd_out=5.
REQ-023 Store, 3-cycle wait: MemWrite_in=1, addr 0x40, data 0x12345678, mem_ready high on the 4th request cycle -> mem_stall high for 3 cycles, mem_we=1, mem_wdata=0x12345678 throughout; bubbles during the stall; RegWrite_out=0 after completion.
REQ-024 Timeout with MAX_WAIT=4 and mem_ready never asserted -> mem_stall high for 4 cycles, then mem_req drops; mem_timeout=1 and stays 1; a bubble is written.
REQ-025 Misaligned: MemRead_in=1, addr 0x102 -> mem_req never asserted; mem_misalign=1; RegWrite_out=0 next cycle.
REQ-026 Reset in the 2nd WAIT cycle -> next edge: mem_req=0, mem_stall=0, all outputs 0, flags cleared; an ALU op (RegWrite_in=1, result 7, Rd=3) then passes with a 1-cycle latency.

Source files
------------

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: issues data-memory requests, stalls upstream while waiting,
// aborts slow accesses after MAX_WAIT stall cycles and filters misaligned addresses.
module mem_access_stage #(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        RegWrite_in,
  input  logic        MemtoReg_in,
  input  logic        MemRead_in,
  input  logic        MemWrite_in,
  input  logic [31:0] ALU_result_in,
  input  logic [31:0] reg_read_data_2_in,
  input  logic [4:0]  EX_MEM_RegisterRd_in,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        mem_stall,
  output logic        RegWrite_out,
  output logic        MemtoReg_out,
  output logic [31:0] mem_read_data_out,
  output logic [31:0] ALU_result_out,
  output logic [4:0]  MEM_WB_RegisterRd_out,
  output logic        mem_timeout,
  output logic        mem_misalign
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  localparam logic [7:0] LP_LAST_WAIT = 8'(MAX_WAIT - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [7:0]  r_wait_cnt;
  logic [7:0]  w_wait_cnt_nxt;

  logic        r_regwrite;
  logic        r_memtoreg;
  logic [31:0] r_read_data;
  logic [31:0] r_alu_result;
  logic [4:0]  r_rd;
  logic        r_timeout;
  logic        r_misalign;

  logic        w_op;
  logic        w_aligned;
  logic        w_is_load;
  logic        w_req;
  logic        w_stall;
  logic        w_load;
  logic        w_bubble;
  logic        w_set_timeout;
  logic        w_set_misalign;
  logic [31:0] w_wb_data;

  assign w_op      = MemRead_in | MemWrite_in;
  assign w_aligned = (ALU_result_in[1:0] == 2'b00);
  // A simultaneous read+write is treated as a store, so it never returns data.
  assign w_is_load = MemRead_in & ~MemWrite_in;
  assign w_wb_data = (w_op && w_is_load) ? mem_rdata : 32'h0;

  // NOTE: every signal written here gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt    = r_state;
    w_wait_cnt_nxt = r_wait_cnt;
    w_req          = 1'b0;
    w_stall        = 1'b0;
    w_load         = 1'b0;
    w_bubble       = 1'b0;
    w_set_timeout  = 1'b0;
    w_set_misalign = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_op) begin
          w_load = 1'b1;
        end else if (!w_aligned) begin
          w_set_misalign = 1'b1;
          w_bubble       = 1'b1;
        end else begin
          w_req = 1'b1;
          if (mem_ready) begin
            w_load = 1'b1;
          end else begin
            w_stall        = 1'b1;
            w_bubble       = 1'b1;
            w_state_nxt    = S_WAIT;
            w_wait_cnt_nxt = 8'd0;
          end
        end
      end
      S_WAIT: begin
        // Final wait slot: request is withdrawn, so mem_ready no longer matters.
        if (r_wait_cnt == LP_LAST_WAIT) begin
          w_set_timeout  = 1'b1;
          w_bubble       = 1'b1;
          w_state_nxt    = S_IDLE;
          w_wait_cnt_nxt = 8'd0;
        end else begin
          w_req = 1'b1;
          if (mem_ready) begin
            w_load         = 1'b1;
            w_state_nxt    = S_IDLE;
            w_wait_cnt_nxt = 8'd0;
          end else begin
            w_stall        = 1'b1;
            w_bubble       = 1'b1;
            w_wait_cnt_nxt = r_wait_cnt + 8'd1;
          end
        end
      end
      default: begin
        w_state_nxt    = S_IDLE;
        w_wait_cnt_nxt = 8'd0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_wait_cnt   <= 8'd0;
      r_regwrite   <= 1'b0;
      r_memtoreg   <= 1'b0;
      r_read_data  <= 32'h0;
      r_alu_result <= 32'h0;
      r_rd         <= 5'd0;
      r_timeout    <= 1'b0;
      r_misalign   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
      if (w_load) begin
        r_regwrite   <= RegWrite_in;
        r_memtoreg   <= MemtoReg_in;
        r_read_data  <= w_wb_data;
        r_alu_result <= ALU_result_in;
        r_rd         <= EX_MEM_RegisterRd_in;
      end else if (w_bubble) begin
        // Bubble kills the write-back controls; data fields keep their last value.
        r_regwrite <= 1'b0;
        r_memtoreg <= 1'b0;
        r_rd       <= 5'd0;
      end
      if (w_set_timeout) begin
        r_timeout <= 1'b1;
      end
      if (w_set_misalign) begin
        r_misalign <= 1'b1;
      end
    end
  end

  assign mem_req   = w_req & ~reset;
  assign mem_stall = w_stall & ~reset;
  assign mem_we    = MemWrite_in;
  assign mem_addr  = ALU_result_in;
  assign mem_wdata = reg_read_data_2_in;

  assign RegWrite_out          = r_regwrite;
  assign MemtoReg_out          = r_memtoreg;
  assign mem_read_data_out     = r_read_data;
  assign ALU_result_out        = r_alu_result;
  assign MEM_WB_RegisterRd_out = r_rd;
  assign mem_timeout           = r_timeout;
  assign mem_misalign          = r_misalign;

endmodule
